sme_feeder: RTL and testbench

SME_FEEDER -- requirements
Module: sme_feeder

---
 rtl/sme_feeder.sv | 237 +++++++++++++++++++++++
 tb/tb_sme_feeder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_feeder.sv
// Host-side feeder for a string/pattern matcher: buffers records, replays them as bursts, collects the result.
// Latency: first burst cycle 1 clk after the pattern's last char is accepted; res_valid 1 clk after matcher valid.
// Backpressure: in_ready is high only while idle or loading; it is low while sending, waiting and reporting.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data       host character handshake
//   in_type, in_last                0 = string / 1 = pattern; last character of the record
//   chardata, isstring, ispattern   character burst towards the matcher
//   valid, match, match_index       matcher result strobe and payload
//   res_valid, res_match,           one-cycle result pulse to the host with held match data
//   res_index, res_seq
//   err_ovf, err_tmo                sticky overflow / matcher-timeout flags
module sme_feeder #(
    parameter int STR_MAX  = 32,
    parameter int PAT_MAX  = 8,
    parameter int WAIT_MAX = 511
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_type,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [3:0] res_seq,
    output logic       err_ovf,
    output logic       err_tmo
);

    // Address widths, length widths (lengths can equal the depth) and the
    // shared send index wide enough for either buffer.
    localparam int SA = $clog2(STR_MAX);
    localparam int PA = $clog2(PAT_MAX);
    localparam int SL = $clog2(STR_MAX + 1);
    localparam int PL = $clog2(PAT_MAX + 1);
    localparam int IL = (SL > PL) ? SL : PL;
    localparam int WW = $clog2(WAIT_MAX + 1);

    localparam logic [SL-1:0] STR_FULL  = SL'(STR_MAX);
    localparam logic [PL-1:0] PAT_FULL  = PL'(PAT_MAX);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_STR,
        S_LOAD_PAT,
        S_SEND_STR,
        S_SEND_PAT,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t        state;
    logic          str_new;
    logic [SL-1:0] str_len;
    logic [PL-1:0] pat_len;
    logic [IL-1:0] send_idx;
    logic [WW-1:0] wait_cnt;

    logic [7:0] str_buf [STR_MAX];
    logic [7:0] pat_buf [PAT_MAX];

    logic          acc;
    logic          first;
    logic          rec_pat;
    logic          str_room;
    logic          pat_room;
    logic [SA-1:0] str_wr_idx;
    logic [PA-1:0] pat_wr_idx;
    logic [IL-1:0] send_nxt;
    logic          str_last;
    logic          pat_last;
    logic [7:0]    pat_head;

    assign in_ready = (state == S_IDLE) || (state == S_LOAD_STR) || (state == S_LOAD_PAT);
    assign acc      = in_valid && in_ready;

    // Record type is latched by the state once a record is under way, so
    // in_type only matters on the first character.
    assign first    = (state == S_IDLE);
    assign rec_pat  = first ? in_type : (state == S_LOAD_PAT);

    assign str_room   = (str_len < STR_FULL);
    assign pat_room   = (pat_len < PAT_FULL);
    assign str_wr_idx = first ? '0 : str_len[SA-1:0];
    assign pat_wr_idx = first ? '0 : pat_len[PA-1:0];

    assign send_nxt = send_idx + IL'(1);
    assign str_last = (send_idx == (IL'(str_len) - IL'(1)));
    assign pat_last = (send_idx == (IL'(pat_len) - IL'(1)));

    // A one-character pattern is written into pat_buf[0] on the same edge
    // that launches the burst, so forward it straight from the input.
    assign pat_head = first ? in_data : pat_buf[0];

    // Buffer storage carries no reset; lengths decide what is valid.
    always_ff @(posedge clk) begin
        if (acc && !rec_pat && (first || str_room)) begin
            str_buf[str_wr_idx] <= in_data;
        end
        if (acc && rec_pat && (first || pat_room)) begin
            pat_buf[pat_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            str_new   <= 1'b0;
            str_len   <= '0;
            pat_len   <= '0;
            send_idx  <= '0;
            wait_cnt  <= '0;
            chardata  <= 8'd0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            res_valid <= 1'b0;
            res_match <= 1'b0;
            res_index <= 5'd0;
            res_seq   <= 4'd0;
            err_ovf   <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE, S_LOAD_STR, S_LOAD_PAT: begin
                    if (acc) begin
                        if (!rec_pat) begin
                            // New string record starts over at index 0.
                            if (first) begin
                                str_len <= SL'(1);
                            end else if (str_room) begin
                                str_len <= str_len + SL'(1);
                            end else begin
                                err_ovf <= 1'b1;
                            end
                            if (in_last) begin
                                str_new <= 1'b1;
                                res_seq <= 4'd0;
                                state   <= S_IDLE;
                            end else begin
                                state   <= S_LOAD_STR;
                            end
                        end else begin
                            if (first) begin
                                pat_len <= PL'(1);
                            end else if (pat_room) begin
                                pat_len <= pat_len + PL'(1);
                            end else begin
                                err_ovf <= 1'b1;
                            end
                            if (in_last) begin
                                send_idx <= '0;
                                if (str_new) begin
                                    state    <= S_SEND_STR;
                                    isstring <= 1'b1;
                                    chardata <= str_buf[0];
                                end else begin
                                    state     <= S_SEND_PAT;
                                    ispattern <= 1'b1;
                                    chardata  <= pat_head;
                                end
                            end else begin
                                state <= S_LOAD_PAT;
                            end
                        end
                    end
                end

                S_SEND_STR: begin
                    if (str_last) begin
                        // Hand over to the pattern burst with no idle cycle.
                        state     <= S_SEND_PAT;
                        isstring  <= 1'b0;
                        ispattern <= 1'b1;
                        chardata  <= pat_buf[0];
                        send_idx  <= '0;
                        str_new   <= 1'b0;
                    end else begin
                        send_idx <= send_nxt;
                        chardata <= str_buf[send_nxt[SA-1:0]];
                    end
                end

                S_SEND_PAT: begin
                    if (pat_last) begin
                        state     <= S_WAIT;
                        ispattern <= 1'b0;
                        chardata  <= 8'd0;
                        wait_cnt  <= '0;
                    end else begin
                        send_idx <= send_nxt;
                        chardata <= pat_buf[send_nxt[PA-1:0]];
                    end
                end

                S_WAIT: begin
                    if (valid) begin
                        state     <= S_REPORT;
                        res_valid <= 1'b1;
                        res_match <= match;
                        res_index <= match ? match_index : 5'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // WAIT_MAX cycles spent here with no result.
                        state     <= S_REPORT;
                        res_valid <= 1'b1;
                        res_match <= 1'b0;
                        res_index <= 5'd0;
                        err_tmo   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end

                S_REPORT: begin
                    res_seq <= res_seq + 4'd1;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
module tb_sme_feeder;

    localparam int WAIT_MAX = 511;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_type;
    logic       in_last;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;
    logic       res_valid;
    logic       res_match;
    logic [4:0] res_index;
    logic [3:0] res_seq;
    logic       err_ovf;
    logic       err_tmo;

    sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_type(in_type), .in_last(in_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .res_seq(res_seq), .err_ovf(err_ovf), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Burst/result monitor, sampled just after each rising edge.
    int         n_str  = 0;
    int         n_pat  = 0;
    int         n_both = 0;
    int         n_gap  = 0;
    int         n_junk = 0;
    int         n_res  = 0;
    logic       prev_str = 1'b0;
    logic [7:0] str_q [$];
    logic [7:0] pat_q [$];

    always @(posedge clk) begin
        #1;
        if (reset) begin
            if (isstring) begin n_str++; str_q.push_back(chardata); end
            if (ispattern) begin n_pat++; pat_q.push_back(chardata); end
            if (isstring && ispattern) n_both++;
            if (!isstring && !ispattern && chardata != 8'd0) n_junk++;
            if (prev_str && !isstring && !ispattern) n_gap++;
            if (res_valid) n_res++;
        end
        prev_str = reset && isstring;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic put_char(input logic typ, input logic [7:0] d, input logic last);
        chk("in_ready_load", in_ready, 1);
        in_valid = 1'b1; in_type = typ; in_data = d; in_last = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_type = 1'b0; in_data = 8'd0; in_last = 1'b0;
    endtask

    task automatic put_str(input logic typ, input string s);
        for (int i = 0; i < s.len(); i++) put_char(typ, s[i], i == s.len() - 1);
    endtask

    task automatic wait_burst_end();
        int k;
        k = 0;
        while ((isstring || ispattern) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("burst_end_bound", k < 100, 1);
    endtask

    task automatic respond(input logic m, input logic [4:0] idx);
        valid = 1'b1; match = m; match_index = idx;
        @(negedge clk);
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
    endtask

    int s0, p0, q0, pq0, r0, cyc;
    logic [63:0] w;

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; in_type = 1'b0; in_last = 1'b0;
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_chardata", chardata, 0);
        chk("rst_isstring", isstring, 0);
        chk("rst_ispattern", ispattern, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_match", res_match, 0);
        chk("rst_res_index", res_index, 0);
        chk("rst_res_seq", res_seq, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_tmo", err_tmo, 0);

        // Matcher's post-reset result arrives while idle: ignored.
        @(negedge clk);
        reset = 1'b1;
        respond(1'b1, 5'd7);
        @(negedge clk);
        chk("idle_valid_no_res", n_res, 0);

        // String "ab cd" is only buffered.
        put_str(1'b0, "ab cd");
        chk("str_rec_no_burst", n_str + n_pat, 0);

        // Pattern "^cd" replays 5 string chars then 3 pattern chars.
        s0 = n_str; p0 = n_pat; q0 = str_q.size(); pq0 = pat_q.size();
        put_str(1'b1, "^cd");
        chk("lat_first_isstring", isstring, 1);
        chk("lat_first_char", chardata, 8'h61);
        wait_burst_end();
        chk("in_ready_wait", in_ready, 0);
        chk("str_burst_len", n_str - s0, 5);
        chk("pat_burst_len", n_pat - p0, 3);
        w = 64'd0;
        for (int i = 0; i < 5; i++) w = {w[55:0], str_q[q0 + i]};
        chk("str_burst_data", w, 64'h6162206364);
        w = 64'd0;
        for (int i = 0; i < 3; i++) w = {w[55:0], pat_q[pq0 + i]};
        chk("pat_burst_data", w, 64'h5e6364);
        respond(1'b1, 5'd3);
        chk("r1_valid", res_valid, 1);
        chk("r1_match", res_match, 1);
        chk("r1_index", res_index, 3);
        chk("r1_seq", res_seq, 0);
        @(negedge clk);
        chk("r1_pulse_width", res_valid, 0);
        chk("r1_seq_inc", res_seq, 1);

        // Pattern "x" without a new string: pattern-only burst.
        s0 = n_str; p0 = n_pat;
        put_str(1'b1, "x");
        chk("p2_first_ispattern", ispattern, 1);
        chk("p2_first_isstring", isstring, 0);
        chk("p2_first_char", chardata, 8'h78);
        wait_burst_end();
        chk("p2_str_len", n_str - s0, 0);
        chk("p2_pat_len", n_pat - p0, 1);
        respond(1'b0, 5'd9);
        chk("r2_valid", res_valid, 1);
        chk("r2_match", res_match, 0);
        chk("r2_index", res_index, 0);
        chk("r2_seq", res_seq, 1);
        @(negedge clk);
        chk("r2_seq_inc", res_seq, 2);
        chk("no_ovf_yet", err_ovf, 0);

        // 34-character string overflows; only 32 replayed.
        for (int i = 0; i < 34; i++) put_char(1'b0, 8'h41 + 8'(i), i == 33);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_seq_cleared", res_seq, 0);
        s0 = n_str; p0 = n_pat; q0 = str_q.size(); pq0 = pat_q.size();
        put_str(1'b1, "z");
        chk("ovf_first_char", chardata, 8'h41);
        wait_burst_end();
        chk("ovf_str_len", n_str - s0, 32);
        chk("ovf_last_str_char", str_q[q0 + 31], 8'h60);
        chk("ovf_pat_char", pat_q[pq0], 8'h7a);

        // Matcher stays silent: timeout report.
        chk("tmo_clear_before", err_tmo, 0);
        cyc = 0;
        while (!res_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_cycles", (cyc >= WAIT_MAX - 1) && (cyc <= WAIT_MAX + 1), 1);
        chk("tmo_flag", err_tmo, 1);
        chk("tmo_res_valid", res_valid, 1);
        chk("tmo_match", res_match, 0);
        chk("tmo_index", res_index, 0);
        chk("tmo_seq", res_seq, 0);
        @(negedge clk);
        chk("tmo_pulse_width", res_valid, 0);
        chk("tmo_seq_inc", res_seq, 1);

        // Stray valid while idle.
        r0 = n_res;
        respond(1'b1, 5'd2);
        @(negedge clk);
        chk("idle_valid_ignored", n_res - r0, 0);

        // Reset in the middle of the string burst.
        put_str(1'b0, "hello");
        put_str(1'b1, "p");
        chk("mid_isstring", isstring, 1);
        chk("mid_char", chardata, 8'h68);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_isstring", isstring, 0);
        chk("mid_rst_ispattern", ispattern, 0);
        chk("mid_rst_chardata", chardata, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_res", {res_valid, res_match, res_index, res_seq}, 0);
        chk("mid_rst_errs", {err_ovf, err_tmo}, 0);
        r0 = n_res;
        @(negedge clk);
        valid = 1'b1; match = 1'b1; match_index = 5'd4;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        @(negedge clk);
        chk("post_rst_valid_ignored", n_res - r0, 0);

        // Pattern with no string loaded since reset.
        s0 = n_str; p0 = n_pat;
        put_str(1'b1, "q");
        chk("nostr_ispattern", ispattern, 1);
        chk("nostr_isstring", isstring, 0);
        wait_burst_end();
        chk("nostr_str_len", n_str - s0, 0);
        chk("nostr_pat_len", n_pat - p0, 1);
        respond(1'b1, 5'd31);
        chk("r4_match", res_match, 1);
        chk("r4_index", res_index, 31);
        chk("r4_seq", res_seq, 0);
        @(negedge clk);

        chk("total_results", n_res, 4);
        chk("never_both", n_both, 0);
        chk("no_burst_gap", n_gap, 0);
        chk("chardata_zero_idle", n_junk, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
